// File: rtl/rle_encoder_pkg.sv
// Purpose: constants and helpers shared by the run-length encoder and decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Instruction word layout: [18] always 0, [17:8] run count minus 1, [7:0] colour.
package rle_encoder_pkg;

  localparam int RGB_W   = 8;
  localparam int RUN_W   = 10;
  localparam int INSTR_W = 19;
  localparam int RUN_MSB = 18;
  localparam int RUN_LSB = 8;
  localparam int MAX_RUN = 1024;

  // Build an instruction word from a (count-1) run field and a colour.
  // The top bit of the run field is reserved and always driven to 0.
  function automatic logic [INSTR_W-1:0] pack_instr(input logic [RUN_W-1:0] run_m1,
                                                    input logic [RGB_W-1:0] rgb);
    logic [INSTR_W-1:0] w;
    w                        = '0;
    w[RUN_MSB-1:RUN_LSB]     = run_m1;
    w[RGB_W-1:0]             = rgb;
    return w;
  endfunction

endpackage

// File: rtl/rle_encoder_if.sv
// Purpose: pixel input stream plus instruction output stream of the encoder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both streams.
//
// master: pixel producer / instruction consumer (environment side).
// slave : the encoder itself.
interface rle_encoder_if;
  import rle_encoder_pkg::*;

  logic [RGB_W-1:0]   pixel_in;
  logic               pixel_valid;
  logic               pixel_last;
  logic               pixel_ready;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output pixel_in,
    output pixel_valid,
    output pixel_last,
    input  pixel_ready,
    input  instruction,
    input  instr_valid,
    output instr_ready
  );

  modport slave (
    input  pixel_in,
    input  pixel_valid,
    input  pixel_last,
    output pixel_ready,
    output instruction,
    output instr_valid,
    input  instr_ready
  );

endinterface

// File: rtl/rle_encoder.sv
// Purpose: run-length encode an 8-bit pixel stream into {run-1, colour} instructions.
// Latency: instruction valid one cycle after the pixel that closes the run is accepted.
// Backpressure: one output slot; pixels stall while the slot is full and unaccepted or while flushing.
//
// Ports: clk (rising edge), rst_n (synchronous, active-low),
//        bus (rle_encoder_if.slave): pixel_in/pixel_valid/pixel_last/pixel_ready in,
//        instruction/instr_valid/instr_ready out.
module rle_encoder #(
  parameter int MAX_RUN = rle_encoder_pkg::MAX_RUN
) (
  input  logic          clk,
  input  logic          rst_n,
  rle_encoder_if.slave  bus
);
  import rle_encoder_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Largest value the count-1 accumulator may reach before a run is forced closed.
  localparam logic [RUN_W-1:0] CNT_MAX = RUN_W'(MAX_RUN - 1);

  state_t             state_q,     state_d;
  logic [RGB_W-1:0]   acc_rgb_q,   acc_rgb_d;
  logic [RUN_W-1:0]   acc_cnt_q,   acc_cnt_d;
  logic [INSTR_W-1:0] instr_q,     instr_d;
  logic               instr_vld_q, instr_vld_d;

  logic               slot_free;
  logic               pix_acc;
  logic               emit;
  logic [INSTR_W-1:0] emit_dat;

  always_comb begin
    // Slot is free if empty or being drained on this edge.
    slot_free = !instr_vld_q || bus.instr_ready;
    bus.pixel_ready = (state_q != FLUSH) && slot_free;
    pix_acc = bus.pixel_valid && bus.pixel_ready;

    state_d   = state_q;
    acc_rgb_d = acc_rgb_q;
    acc_cnt_d = acc_cnt_q;
    emit      = 1'b0;
    emit_dat  = '0;

    unique case (state_q)
      IDLE: begin
        if (pix_acc) begin
          if (bus.pixel_last) begin
            // Single-pixel line: emit immediately, nothing stays open.
            emit     = 1'b1;
            emit_dat = pack_instr('0, bus.pixel_in);
          end else begin
            acc_rgb_d = bus.pixel_in;
            acc_cnt_d = '0;
            state_d   = RUN;
          end
        end
      end

      RUN: begin
        if (pix_acc) begin
          if ((bus.pixel_in == acc_rgb_q) && (acc_cnt_q < CNT_MAX)) begin
            acc_cnt_d = acc_cnt_q + RUN_W'(1);
            if (bus.pixel_last) begin
              emit     = 1'b1;
              emit_dat = pack_instr(acc_cnt_q + RUN_W'(1), acc_rgb_q);
              state_d  = IDLE;
            end
          end else begin
            // Close the current run and start a new one with this pixel.
            // If this pixel is also the last, it still needs its own
            // instruction, which FLUSH issues once the slot frees up.
            emit      = 1'b1;
            emit_dat  = pack_instr(acc_cnt_q, acc_rgb_q);
            acc_rgb_d = bus.pixel_in;
            acc_cnt_d = '0;
            state_d   = bus.pixel_last ? FLUSH : RUN;
          end
        end
      end

      FLUSH: begin
        if (slot_free) begin
          emit     = 1'b1;
          emit_dat = pack_instr(acc_cnt_q, acc_rgb_q);
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Slot: drains on acceptance; a same-edge load keeps it full (no bubble).
    instr_vld_d = instr_vld_q && !bus.instr_ready;
    instr_d     = instr_q;
    if (emit) begin
      instr_vld_d = 1'b1;
      instr_d     = emit_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_rgb_q   <= '0;
      acc_cnt_q   <= '0;
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_rgb_q   <= acc_rgb_d;
      acc_cnt_q   <= acc_cnt_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = instr_vld_q;

endmodule

// File: tb/tb_rle_encoder.sv
// Purpose: self-checking bench for rle_encoder with a run-list model and an inline decoder.
// Latency: n/a (testbench).
// Backpressure: instr_ready driven always-high, always-low or random per phase.
module tb_rle_encoder;
  import rle_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rle_encoder_if bus ();

  rle_encoder #(.MAX_RUN(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

  logic [18:0] exp_q[$];   // instructions the model says must appear, in order
  logic [18:0] rx_log[$];  // every instruction the consumer accepted
  logic [7:0]  in_q[$];    // accepted pixels not yet covered by a decoded instruction

  // Model of the open run: colour and true pixel count (not count-1).
  logic       m_open = 1'b0;
  logic [7:0] m_rgb  = 8'h00;
  int         m_len  = 0;

  logic        prev_hold = 1'b0;
  logic [18:0] prev_instr = '0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] mk(input int len, input logic [7:0] c);
    return {1'b0, 10'(len - 1), c};
  endfunction

  // Runs end on colour change, on reaching 1024 pixels, or on a last pixel.
  task automatic model_pixel(input logic [7:0] p, input logic last);
    if (m_open && p == m_rgb && m_len < 1024) begin
      m_len++;
    end else begin
      if (m_open) exp_q.push_back(mk(m_len, m_rgb));
      m_rgb  = p;
      m_len  = 1;
      m_open = 1'b1;
    end
    if (last) begin
      exp_q.push_back(mk(m_len, m_rgb));
      m_open = 1'b0;
    end
  endtask

  // Consumer ready generator, updated just after each rising edge.
  initial bus.instr_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.instr_ready = 1'b1;
      1:       bus.instr_ready = 1'($urandom_range(0, 1));
      default: bus.instr_ready = 1'b0;
    endcase
  end

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int run;
    if (!rst_n) begin
      exp_q.delete();
      in_q.delete();
      m_open    = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("hold_data", 32'(bus.instruction), 32'(prev_instr));
      end
      if (bus.instr_valid && !bus.instr_ready)
        check_eq("ready_blocked", 32'(bus.pixel_ready), 32'd0);
      if (bus.instr_valid && bus.instr_ready) begin
        rx_log.push_back(bus.instruction);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL instr: got 0x%0h expected none", bus.instruction);
        end else begin
          check_eq("instr", 32'(bus.instruction), 32'(exp_q.pop_front()));
        end
        check_eq("bit18", 32'(bus.instruction[18]), 32'd0);
        // Decode the instruction and match it against the accepted pixels.
        run = int'(bus.instruction[17:8]);
        for (int i = 0; i <= run; i++) begin
          if (in_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL decode: got extra pixel 0x%0h expected none", bus.instruction[7:0]);
            break;
          end
          check_eq("decode", 32'(bus.instruction[7:0]), 32'(in_q.pop_front()));
        end
      end
      if (bus.pixel_valid && bus.pixel_ready) begin
        in_q.push_back(bus.pixel_in);
        model_pixel(bus.pixel_in, bus.pixel_last);
      end
      prev_hold  = bus.instr_valid && !bus.instr_ready;
      prev_instr = bus.instruction;
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] p, input logic last);
    int t = 0;
    bus.pixel_in    = p;
    bus.pixel_last  = last;
    bus.pixel_valid = 1'b1;
    @(negedge clk);
    while (!bus.pixel_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no pixel_ready expected accept within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.pixel_valid = 1'b0;
    bus.pixel_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.instr_valid) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [7:0] pal [3];
    pal[0] = 8'h00; pal[1] = 8'h5A; pal[2] = 8'hC3;
    bus.pixel_in    = '0;
    bus.pixel_valid = 1'b0;
    bus.pixel_last  = 1'b0;

    // Reset values
    repeat (3) step();
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_instr", 32'(bus.instruction), 32'd0);
    rst_n = 1'b1;
    check_eq("rst_ready", 32'(bus.pixel_ready), 32'd1);

    // 0x1C x5, 0xE0 x3; a stray pixel_last without valid mid-run is ignored
    n = rx_log.size();
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    bus.pixel_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stray_last", 32'(bus.instr_valid), 32'd0);
    end
    bus.pixel_last = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h1C, 1'b0);
    send(8'hE0, 1'b0);
    send(8'hE0, 1'b0);
    send(8'hE0, 1'b1);
    drain();
    check_eq("v1_count", 32'(rx_log.size()), 32'(n + 2));
    if (rx_log.size() == n + 2) begin
      check_eq("v1_first", 32'(rx_log[n]), 32'h0041C);
      check_eq("v1_second", 32'(rx_log[n+1]), 32'h002E0);
    end
    check_eq("v1_idle", 32'(bus.pixel_ready), 32'd1);

    // 1030 pixels of 0x03: full 1024 run then a 6-pixel run
    n = rx_log.size();
    for (int i = 0; i < 1029; i++) send(8'h03, 1'b0);
    send(8'h03, 1'b1);
    drain();
    check_eq("v2_count", 32'(rx_log.size()), 32'(n + 2));
    if (rx_log.size() == n + 2) begin
      check_eq("v2_max", 32'(rx_log[n]), 32'h3FF03);
      check_eq("v2_rest", 32'(rx_log[n+1]), 32'h00503);
    end

    // 0xFF x4 then 0x00 last: one FLUSH cycle
    for (int i = 0; i < 4; i++) send(8'hFF, 1'b0);
    send(8'h00, 1'b1);
    check_eq("v3_flush_ready", 32'(bus.pixel_ready), 32'd0);
    check_eq("v3_first", 32'(bus.instruction), 32'h003FF);
    step();
    check_eq("v3_second", 32'(bus.instruction), 32'h00000);
    check_eq("v3_second_vld", 32'(bus.instr_valid), 32'd1);
    check_eq("v3_idle_ready", 32'(bus.pixel_ready), 32'd1);
    drain();

    // Backpressure: slot held for 10 cycles
    n = rx_log.size();
    rdy_mode = 2;
    send(8'h11, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check_eq("v4_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("v4_data", 32'(bus.instruction), 32'h00111);
      check_eq("v4_ready", 32'(bus.pixel_ready), 32'd0);
      step();
    end
    rdy_mode = 0;
    send(8'h33, 1'b1);
    drain();
    check_eq("v4_count", 32'(rx_log.size()), 32'(n + 3));
    if (rx_log.size() == n + 3) begin
      check_eq("v4_a", 32'(rx_log[n]), 32'h00111);
      check_eq("v4_b", 32'(rx_log[n+1]), 32'h00022);
      check_eq("v4_c", 32'(rx_log[n+2]), 32'h00033);
    end

    // Reset mid-run with a pending instruction discards both
    n = rx_log.size();
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    rst_n = 1'b0;
    step();
    check_eq("v5_rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("v5_rst_instr", 32'(bus.instruction), 32'd0);
    rst_n    = 1'b1;
    rdy_mode = 0;
    check_eq("v5_rst_ready", 32'(bus.pixel_ready), 32'd1);
    send(8'h55, 1'b0);
    send(8'h55, 1'b0);
    send(8'h55, 1'b1);
    drain();
    check_eq("v5_count", 32'(rx_log.size()), 32'(n + 1));
    if (rx_log.size() == n + 1)
      check_eq("v5_fresh", 32'(rx_log[n]), 32'h00255);

    // Random pixels with random backpressure and idle gaps
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(pal[$urandom_range(0, 2)], (i == 399) || ($urandom_range(0, 19) == 0));
    end
    drain();
    rdy_mode = 0;
    check_eq("rand_leftover_pixels", 32'(in_q.size()), 32'd0);
    check_eq("rand_leftover_instr", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rle_encoder.md
RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 SHALL have ports, clock and reset first: clk  input  1  sole clock, all logic on rising edge.
REQ-002 rst_n  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-003 pixel_in  input  8  pixel colour, RRRGGGBB.
REQ-004 pixel_valid  input  1  pixel_in valid this cycle.
REQ-005 pixel_last  input  1  qualifies the accepted pixel as final of line/frame; forces flush.
REQ-006 pixel_ready  output  1  encoder accepts pixel when pixel_valid && pixel_ready.
REQ-007 instruction  output  19  [18:8] run field = run count minus 1, bit 18 always 0; [7:0] colour.
REQ-008 instr_valid  output  1  instruction valid; held with stable data until accepted.
REQ-009 instr_ready  input  1  consumer accepts instruction when instr_valid && instr_ready.
REQ-010 Parameter MAX_RUN, default 1024, maximum pixels per instruction (run field 1023).

Function
REQ-011 State machine SHALL have states IDLE (no open run), RUN (open run in accumulator), FLUSH (open run must be emitted, no input accepted).
REQ-012 Accumulator: acc_rgb 8 bits, acc_cnt 10 bits holding count-1.
REQ-013 Single output slot; pixel_ready SHALL equal (state != FLUSH) && (!instr_valid || instr_ready).
REQ-014 IDLE, accepted pixel, not last: acc_rgb=pixel_in, acc_cnt=0, go RUN.
REQ-015 IDLE, accepted pixel, last: emit {0, 10'd0, pixel_in} to slot, stay IDLE.
REQ-016 RUN, accepted pixel equal to acc_rgb and acc_cnt < 1023: acc_cnt increments; if pixel_last also, emit {0, acc_cnt+1, acc_rgb}, go IDLE.
REQ-017 RUN, accepted pixel differs or acc_cnt == 1023: emit {0, acc_cnt, acc_rgb}, reload acc_rgb=pixel_in, acc_cnt=0; next state RUN, or FLUSH if pixel_last.
REQ-018 FLUSH: when slot free (!instr_valid || instr_ready) emit {0, acc_cnt, acc_rgb}, go IDLE; otherwise hold.
REQ-019 Emitting loads slot on the same edge; instr_valid rises cycle after the terminating pixel is accepted (latency 1).
REQ-020 Slot: instr_valid clears on acceptance unless reloaded same edge; simultaneous accept and load SHALL yield back-to-back instructions with no bubble.
REQ-021 No pixel dropped or duplicated; sum over emitted (run field+1) SHALL equal accepted pixel count once flushed.
REQ-022 pixel_last with pixel_valid low SHALL be ignored; no spontaneous flush without pixel_last.
REQ-023 Run of exactly 1024 equal pixels SHALL emit one instruction with run field 1023; pixel 1025 starts a new run.

Reset
REQ-024 On rst_n low: state IDLE, acc_cnt 0, acc_rgb 0, instr_valid 0, instruction 0; pixel_ready 1 in the first cycle after reset release.
REQ-025 Reset mid-run or with pending instruction SHALL discard accumulator and slot without emitting.

Structure
REQ-026 Shared package SHALL hold RGB_W=8, RUN_W=10, INSTR_W=19, RUN_MSB=18, RUN_LSB=8, MAX_RUN=1024, shared with the decoder side.
REQ-027 State encoding typedef SHALL be local to this module.
REQ-028 Single module; no sub-module required.

Verification
REQ-029 Pixels 0x1C x5, 0xE0 x3 (last on final), instr_ready=1 -> instructions 0x0041C then 0x002E0, then IDLE.
REQ-030 1030 pixels of 0x03, last on final -> 0x3FF03 then 0x00503.
REQ-031 0xFF x4 then 0x00 with last -> 0x003FF, FLUSH one cycle, then 0x00000; pixel_ready low during FLUSH.
REQ-032 instr_ready=0 for 10 cycles with a pending instruction -> instr_valid and instruction stable, pixel_ready low once a new emit is needed, no loss after release.
REQ-033 rst_n low mid-run of 0x55 x7 -> no instruction emitted, outputs at reset values, next run encodes from zero.
REQ-034 Random pixels and backpressure, encoder output fed to the run-length decoder -> decoded stream identical to input.
